// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: two-master req/ack arbiter for the peripheral bus.
// Optional ARB_ADDR_CHECK_EN: reject out-of-range or misaligned accesses.
module periph_bus_arbiter #(
  parameter bit          RR_EN      = 1'b1,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter logic [31:0] LIMIT_ADDR = 32'h4000_0014
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        s_rd,
  output logic        s_wr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_sel;
  logic        r_last;
  logic        r_bad;

  logic        w_pick1;
  logic        w_gnt_wr;
  logic [31:0] w_gnt_addr;
  logic [31:0] w_gnt_wdata;
  logic        w_oob;
  logic        w_bad;
  logic [31:0] w_cap;

  // Pick the master to grant in IDLE and mux its command
  always_comb begin
    w_pick1     = m1_req & (~m0_req | (RR_EN & ~r_last));
    w_gnt_wr    = w_pick1 ? m1_wr    : m0_wr;
    w_gnt_addr  = w_pick1 ? m1_addr  : m0_addr;
    w_gnt_wdata = w_pick1 ? m1_wdata : m0_wdata;
    w_oob       = (w_gnt_addr < BASE_ADDR) |
                  (w_gnt_addr > LIMIT_ADDR) |
                  (w_gnt_addr[1:0] != 2'b00);
    w_cap       = s_rd ? s_rdata : 32'h0;
  end

`ifdef ARB_ADDR_CHECK_EN
  assign w_bad = w_oob;
`else
  // Range logic is computed but folds away when the check is off
  assign w_bad = w_oob & 1'b0;
`endif

  // IDLE -> XFER -> ACK sequencer with registered bus and ack outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_sel    <= 1'b0;
      r_last   <= 1'b1;
      r_bad    <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= 32'h0;
      m1_rdata <= 32'h0;
      s_rd     <= 1'b0;
      s_wr     <= 1'b0;
      s_addr   <= 32'h0;
      s_wdata  <= 32'h0;
      err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_req | m1_req) begin
            r_sel   <= w_pick1;
            r_bad   <= w_bad;
            s_addr  <= w_gnt_addr;
            s_wdata <= w_gnt_wdata;
            s_rd    <= ~w_gnt_wr & ~w_bad;
            s_wr    <= w_gnt_wr & ~w_bad;
            r_state <= XFER;
          end
        end
        XFER: begin
          s_rd   <= 1'b0;
          s_wr   <= 1'b0;
          r_last <= r_sel;
          err    <= r_bad;
          if (r_sel) begin
            m1_rdata <= w_cap;
            m1_ack   <= 1'b1;
          end else begin
            m0_rdata <= w_cap;
            m0_ack   <= 1'b1;
          end
          r_state <= ACK;
        end
        ACK: begin
          m0_ack  <= 1'b0;
          m1_ack  <= 1'b0;
          err     <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          s_rd    <= 1'b0;
          s_wr    <= 1'b0;
          m0_ack  <= 1'b0;
          m1_ack  <= 1'b0;
          err     <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: randomized checks of periph_bus_arbiter
// against a transaction-level model of grant order, timing and data.
module tb_periph_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_wr = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_wr = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m0_ack, m1_ack, s_rd, s_wr, err;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;

  logic        fp_m0_ack, fp_m1_ack, fp_s_rd, fp_s_wr, fp_err;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;

  int vec = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] mem [0:5];
  logic [31:0] ref_mem [0:5];
  logic        init = 1'b1;
  int          wcnt = 0;
  int          rd_cnt = 0, wr_cnt = 0;
  int          m0_acks = 0, m1_acks = 0;
  int          fp0_acks = 0, fp1_acks = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  int          model_last = 1;

  periph_bus_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .s_rd(s_rd), .s_wr(s_wr), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .err(err)
  );

  periph_bus_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(fp_m0_ack), .m0_rdata(fp_m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(fp_m1_ack), .m1_rdata(fp_m1_rdata),
    .s_rd(fp_s_rd), .s_wr(fp_s_wr), .s_addr(fp_s_addr),
    .s_wdata(fp_s_wdata), .s_rdata(32'h0), .err(fp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int i);
    return (i == 4) ? 32'h0000_00A5 : 32'h1000 + 32'(i);
  endfunction

  function automatic logic [31:0] addr_of(input int i);
    return 32'h4000_0000 + 32'(i * 4);
  endfunction

  // Peripheral register file: combinational read, write on clock edge
  assign s_rdata = (s_rd && s_addr[4:2] < 3'd6) ? mem[s_addr[4:2]] : 32'h0;

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 6; i++) mem[i] <= init_val(i);
    end else if (s_wr && s_addr[4:2] < 3'd6) begin
      mem[s_addr[4:2]] <= s_wdata;
      wcnt = wcnt + 1;
    end
  end

  // Cycle monitor: strobe/ack bookkeeping and invariants
  always @(negedge clk) begin
    if (s_rd) rd_cnt = rd_cnt + 1;
    if (s_wr) wr_cnt = wr_cnt + 1;
    if (s_rd || s_wr) begin
      last_addr  = s_addr;
      last_wdata = s_wdata;
    end
    if (m0_ack) m0_acks = m0_acks + 1;
    if (m1_ack) m1_acks = m1_acks + 1;
    if (fp_m0_ack) fp0_acks = fp0_acks + 1;
    if (fp_m1_ack) fp1_acks = fp1_acks + 1;
    if (reset) begin
      vec++;
      if ((m0_ack && m1_ack) !== 1'b0) begin
        bad++;
        $display("FAIL both_ack cyc=%0d got=1 want=0", cyc);
      end
      vec++;
      if ((s_rd && s_wr) !== 1'b0) begin
        bad++;
        $display("FAIL both_strobe cyc=%0d got=1 want=0", cyc);
      end
`ifndef ARB_ADDR_CHECK_EN
      vec++;
      if (err !== 1'b0) begin
        bad++;
        $display("FAIL err_tied cyc=%0d got=%b want=0", cyc, err);
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int m, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_req = 1'b1; m0_wr = w; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = 1'b1; m1_wr = w; m1_addr = a; m1_wdata = d;
    end
  endtask

  task automatic stop(input int m);
    if (m == 0) m0_req = 1'b0;
    else m1_req = 1'b0;
  endtask

  task automatic wait_ack(input int m, output int at,
                          output logic [31:0] rd, output logic e);
    at = -1; rd = '0; e = 1'b0;
    for (int i = 0; i < 20 && at < 0; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_ack : m1_ack) begin
        at = cyc;
        rd = (m == 0) ? m0_rdata : m1_rdata;
        e  = err;
      end
    end
  endtask

  task automatic wait_any(output int who, output int at);
    who = -1; at = -1;
    for (int i = 0; i < 20 && at < 0; i++) begin
      @(negedge clk);
      if (m0_ack) begin who = 0; at = cyc; end
      else if (m1_ack) begin who = 1; at = cyc; end
    end
  endtask

  task automatic test_reset();
    #3;
    vec++;
    if ({m0_ack, m1_ack, s_rd, s_wr, err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {m0_ack, m1_ack, s_rd, s_wr, err});
    end
    vec++;
    if ({m0_rdata, m1_rdata, s_addr, s_wdata} !== 128'h0) begin
      bad++;
      $display("FAIL reset_data got=%h %h %h %h want=0",
               m0_rdata, m1_rdata, s_addr, s_wdata);
    end
    @(posedge clk);
    #1 init = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_last = 1;
    tick();
  endtask

  task automatic test_single_read();
    int c, at, r0, w0, a1;
    logic [31:0] rd;
    logic e;
    tick();
    c = cyc; r0 = rd_cnt; w0 = wr_cnt; a1 = m1_acks;
    start(0, 1'b0, 32'h4000_0010, 32'h0);
    wait_ack(0, at, rd, e);
    tick();
    stop(0);
    model_last = 0;
    vec++;
    if (at !== c + 2) begin
      bad++;
      $display("FAIL rd_ack_cycle got=%0d want=%0d", at, c + 2);
    end
    vec++;
    if (rd !== ref_mem[4]) begin
      bad++;
      $display("FAIL rd_data got=%h want=%h", rd, ref_mem[4]);
    end
    vec++;
    if (rd_cnt - r0 !== 1 || wr_cnt != w0 || last_addr !== 32'h4000_0010) begin
      bad++;
      $display("FAIL rd_strobe got rd=%0d wr=%0d a=%h want 1 0 40000010",
               rd_cnt - r0, wr_cnt - w0, last_addr);
    end
    vec++;
    if (m1_acks !== a1) begin
      bad++;
      $display("FAIL rd_m1_quiet got=%0d want=%0d", m1_acks, a1);
    end
  endtask

  task automatic test_single_write();
    int c, at, r0, w0;
    logic [31:0] rd;
    logic e;
    tick();
    c = cyc; r0 = rd_cnt; w0 = wr_cnt;
    start(1, 1'b1, 32'h4000_000C, 32'h0000_003C);
    wait_ack(1, at, rd, e);
    tick();
    stop(1);
    ref_mem[3] = 32'h3C;
    model_last = 1;
    vec++;
    if (at !== c + 2) begin
      bad++;
      $display("FAIL wr_ack_cycle got=%0d want=%0d", at, c + 2);
    end
    vec++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL wr_rdata got=%h want=0", rd);
    end
    vec++;
    if (wr_cnt - w0 !== 1 || rd_cnt != r0 ||
        last_addr !== 32'h4000_000C || last_wdata !== 32'h3C) begin
      bad++;
      $display("FAIL wr_strobe got wr=%0d rd=%0d a=%h d=%h want 1 0 4000000c 3c",
               wr_cnt - w0, rd_cnt - r0, last_addr, last_wdata);
    end
    vec++;
    if (mem[3] !== 32'h3C) begin
      bad++;
      $display("FAIL wr_mem got=%h want=3c", mem[3]);
    end
  endtask

  task automatic test_tie();
    int c, who, at, f0, f1, exp_who;
    c = 0; who = 0; at = 0;
    tick();
    c = cyc; f0 = fp0_acks; f1 = fp1_acks;
    start(0, 1'b0, addr_of(0), 32'h0);
    start(1, 1'b0, addr_of(1), 32'h0);
    for (int k = 0; k < 4; k++) begin
      exp_who = (model_last == 1) ? 0 : 1;
      wait_any(who, at);
      vec++;
      if (who !== exp_who || at !== c + 2 + 3 * k) begin
        bad++;
        $display("FAIL tie_grant k=%0d got m%0d@%0d want m%0d@%0d",
                 k, who, at, exp_who, c + 2 + 3 * k);
      end
      model_last = exp_who;
    end
    tick();
    stop(0);
    stop(1);
    @(negedge clk);
    vec++;
    if (fp0_acks - f0 !== 4 || fp1_acks != f1) begin
      bad++;
      $display("FAIL fixed_prio got m0=%0d m1=%0d want 4 0",
               fp0_acks - f0, fp1_acks - f1);
    end
  endtask

  task automatic test_late_request();
    int c, at, a1;
    logic [31:0] rd;
    logic e;
    tick();
    c = cyc; a1 = m1_acks;
    start(0, 1'b0, addr_of(2), 32'h0);
    tick();
    start(1, 1'b0, addr_of(5), 32'h0);
    wait_ack(0, at, rd, e);
    tick();
    stop(0);
    vec++;
    if (at !== c + 2 || m1_acks !== a1) begin
      bad++;
      $display("FAIL late_m0 got ack@%0d m1acks=%0d want @%0d %0d",
               at, m1_acks - a1, c + 2, 0);
    end
    wait_ack(1, at, rd, e);
    tick();
    stop(1);
    model_last = 1;
    vec++;
    if (at !== c + 5 || rd !== ref_mem[5]) begin
      bad++;
      $display("FAIL late_m1 got @%0d %h want @%0d %h",
               at, rd, c + 5, ref_mem[5]);
    end
  endtask

  task automatic test_reset_mid();
    int a0, a1, wc;
    logic [31:0] d;
    d = $urandom;
    tick();
    start(0, 1'b1, addr_of(0), d);
    tick();
    a0 = m0_acks; a1 = m1_acks; wc = wcnt;
    vec++;
    if (s_wr !== 1'b1) begin
      bad++;
      $display("FAIL mid_xfer_wr got=%b want=1", s_wr);
    end
    #1 reset = 1'b0;
    #1;
    vec++;
    if ({s_rd, s_wr, m0_ack, m1_ack, err} !== 5'b0 ||
        {s_addr, s_wdata, m0_rdata, m1_rdata} !== 128'h0) begin
      bad++;
      $display("FAIL mid_reset_out got=%b %h %h want 0",
               {s_rd, s_wr, m0_ack, m1_ack, err}, s_addr, s_wdata);
    end
    stop(0);
    tick();
    @(negedge clk);
    reset = 1'b1;
    model_last = 1;
    repeat (4) tick();
    vec++;
    if (m0_acks !== a0 || m1_acks !== a1 || wcnt !== wc ||
        mem[0] !== ref_mem[0]) begin
      bad++;
      $display("FAIL mid_no_effect got acks=%0d,%0d wr=%0d mem=%h want 0 0 0 %h",
               m0_acks - a0, m1_acks - a1, wcnt - wc, mem[0], ref_mem[0]);
    end
  endtask

  task automatic test_random();
    int c, at, mask, first, second, n;
    int idx [2];
    logic w [2];
    logic [31:0] d [2];
    logic [31:0] rd, exp;
    logic e;
    for (int it = 0; it < 40; it++) begin
      tick();
      c = cyc;
      mask = $urandom_range(1, 3);
      for (int m = 0; m < 2; m++) begin
        idx[m] = $urandom_range(0, 5);
        w[m]   = 1'($urandom_range(0, 1));
        d[m]   = $urandom;
        if (mask[m]) start(m, w[m], addr_of(idx[m]), d[m]);
      end
      if (mask == 3) begin
        first  = (model_last == 1) ? 0 : 1;
        second = 1 - first;
        n = 2;
      end else begin
        first  = (mask == 1) ? 0 : 1;
        second = first;
        n = 1;
      end
      for (int k = 0; k < n; k++) begin
        int m;
        m = (k == 0) ? first : second;
        wait_ack(m, at, rd, e);
        tick();
        stop(m);
        exp = w[m] ? 32'h0 : ref_mem[idx[m]];
        if (w[m]) ref_mem[idx[m]] = d[m];
        model_last = m;
        vec++;
        if (at !== c + 2 + 3 * k || rd !== exp) begin
          bad++;
          $display("FAIL rand it=%0d m%0d got @%0d %h want @%0d %h",
                   it, m, at, rd, c + 2 + 3 * k, exp);
        end
      end
    end
  endtask

`ifdef ARB_ADDR_CHECK_EN
  task automatic test_addr_check();
    int c, at, r0;
    logic [31:0] rd;
    logic e;
    tick();
    c = cyc; r0 = rd_cnt;
    start(0, 1'b0, 32'h4000_0020, 32'h0);
    wait_ack(0, at, rd, e);
    tick();
    stop(0);
    model_last = 0;
    vec++;
    if (at !== c + 2 || rd !== 32'h0 || e !== 1'b1 || rd_cnt != r0) begin
      bad++;
      $display("FAIL chk_bad got @%0d %h err=%b rd=%0d want @%0d 0 1 0",
               at, rd, e, rd_cnt - r0, c + 2);
    end
    tick();
    c = cyc; r0 = rd_cnt;
    start(0, 1'b0, 32'h4000_0008, 32'h0);
    wait_ack(0, at, rd, e);
    tick();
    stop(0);
    vec++;
    if (at !== c + 2 || rd !== ref_mem[2] || e !== 1'b0 || rd_cnt - r0 != 1) begin
      bad++;
      $display("FAIL chk_good got @%0d %h err=%b rd=%0d want @%0d %h 0 1",
               at, rd, e, rd_cnt - r0, c + 2, ref_mem[2]);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 6; i++) ref_mem[i] = init_val(i);
    test_reset();
    test_single_read();
    test_single_write();
    test_tie();
    test_late_request();
    test_reset_mid();
`ifdef ARB_ADDR_CHECK_EN
    test_addr_check();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
